// File: rtl/field_join_pkg.sv
// rtl/field_join_pkg.sv - shared types and helpers for the split-field join
package field_join_pkg;

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        HAVE_A    = 2'd1,
        HAVE_B    = 2'd2,
        HAVE_BOTH = 2'd3
    } join_state_t;

    // Increment that sticks at the all-ones value of a 'width'-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage

// File: rtl/field_join_slot.sv
// rtl/field_join_slot.sv - one-entry hold register for a single field half
module field_join_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic         valid_o
);

    logic [W-1:0] data_q;
    logic         valid_q;

    // Load beats clear so a new half can refill the slot on the join edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            valid_q <= 1'b1;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/field_join.sv
// rtl/field_join.sv - rejoins independently handshaked upper/lower halves into one word
module field_join
    import field_join_pkg::*;
#(
    parameter int A_W     = 8,
    parameter int B_W     = 8,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [A_W-1:0]       a_data,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [B_W-1:0]       b_data,
    input  logic                 b_valid,
    output logic                 b_ready,
    output logic [A_W+B_W-1:0]   data_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 orphan_err,
    output logic [CNT_W-1:0]     orphan_cnt
);

    localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [A_W-1:0]     hold_a;
    logic [B_W-1:0]     hold_b;
    logic               hold_a_vld, hold_b_vld;
    logic               a_acc, b_acc, join_fire, expire;
    join_state_t        state;

    logic [WAIT_W-1:0]      wait_q, wait_d;
    logic                   out_valid_q, out_valid_d;
    logic [A_W+B_W-1:0]     data_q, data_d;
    logic                   err_q, err_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    assign state     = join_state_t'({hold_b_vld, hold_a_vld});
    assign join_fire = hold_a_vld & hold_b_vld & (~out_valid_q | out_ready);
    assign a_ready   = ~hold_a_vld | join_fire;
    assign b_ready   = ~hold_b_vld | join_fire;
    assign a_acc     = a_valid & a_ready;
    assign b_acc     = b_valid & b_ready;

    field_join_slot #(.W(A_W)) u_slot_a (
        .clk     (clk),
        .rst     (rst),
        .load_i  (a_acc),
        .clear_i (join_fire | expire),
        .data_i  (a_data),
        .data_o  (hold_a),
        .valid_o (hold_a_vld)
    );

    field_join_slot #(.W(B_W)) u_slot_b (
        .clk     (clk),
        .rst     (rst),
        .load_i  (b_acc),
        .clear_i (join_fire | expire),
        .data_i  (b_data),
        .data_o  (hold_b),
        .valid_o (hold_b_vld)
    );

    always_comb begin
        wait_d      = '0;
        expire      = 1'b0;
        out_valid_d = out_valid_q;
        data_d      = data_q;
        err_d       = 1'b0;
        cnt_d       = cnt_q;

        // A lone half ages until its partner arrives; arrival on the last cycle still wins.
        case (state)
            HAVE_A: if (TIMEOUT > 0 && !b_acc) begin
                if (wait_q == WAIT_LAST) expire = 1'b1;
                else                     wait_d = wait_q + 1'b1;
            end
            HAVE_B: if (TIMEOUT > 0 && !a_acc) begin
                if (wait_q == WAIT_LAST) expire = 1'b1;
                else                     wait_d = wait_q + 1'b1;
            end
            default: ;
        endcase

        if (join_fire) begin
            out_valid_d = 1'b1;
            data_d      = {hold_a, hold_b};
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (expire) begin
            err_d = 1'b1;
            cnt_d = CNT_W'(sat_inc(32'(cnt_q), CNT_W));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q      <= '0;
            out_valid_q <= 1'b0;
            data_q      <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            wait_q      <= wait_d;
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign data_out   = data_q;
    assign out_valid  = out_valid_q;
    assign orphan_err = err_q;
    assign orphan_cnt = cnt_q;

endmodule

// File: tb/tb_field_join.sv
// tb/tb_field_join.sv - directed vector bench for field_join
module tb_field_join;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [7:0]  a_data, b_data;
    logic        a_valid, b_valid, a_ready, b_ready;
    logic [15:0] data_out;
    logic        out_valid, out_ready, orphan_err;
    logic [7:0]  orphan_cnt;

    logic [7:0]  t_a_data, t_b_data;
    logic        t_a_valid, t_b_valid, t_a_ready, t_b_ready;
    logic [15:0] t_data_out;
    logic        t_out_valid, t_out_ready, t_orphan_err;
    logic [1:0]  t_orphan_cnt;

    field_join dut (
        .clk(clk), .rst(rst),
        .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
        .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready),
        .orphan_err(orphan_err), .orphan_cnt(orphan_cnt)
    );

    field_join #(.TIMEOUT(4), .CNT_W(2)) dut_t (
        .clk(clk), .rst(rst),
        .a_data(t_a_data), .a_valid(t_a_valid), .a_ready(t_a_ready),
        .b_data(t_b_data), .b_valid(t_b_valid), .b_ready(t_b_ready),
        .data_out(t_data_out), .out_valid(t_out_valid), .out_ready(t_out_ready),
        .orphan_err(t_orphan_err), .orphan_cnt(t_orphan_cnt)
    );

    typedef struct {
        logic        av;
        logic [7:0]  ad;
        logic        bv;
        logic [7:0]  bd;
        logic        ordy;
        logic        ar;
        logic        br;
        logic        ov;
        logic [15:0] dout;
        logic        err;
    } vec_t;

    vec_t vq[$];
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic v(input logic av, input logic [7:0] ad, input logic bv, input logic [7:0] bd,
                     input logic ordy, input logic ar, input logic br, input logic ov,
                     input logic [15:0] dout, input logic err);
        vq.push_back('{av, ad, bv, bd, ordy, ar, br, ov, dout, err});
    endtask

    initial begin
        logic [7:0] e;
        logic [1:0] sat_exp [3];

        rst = 1'b1;
        a_valid = 1'b0; a_data = 8'h00; b_valid = 1'b0; b_data = 8'h00; out_ready = 1'b1;
        t_a_valid = 1'b0; t_a_data = 8'h00; t_b_valid = 1'b0; t_b_data = 8'h00; t_out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;

        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_orphan_err", 32'(orphan_err), 32'd0);
        check("rst_orphan_cnt", 32'(orphan_cnt), 32'd0);
        check("rst_a_ready", 32'(a_ready), 32'd1);
        check("rst_b_ready", 32'(b_ready), 32'd1);

        // av ad bv bd ordy | ar br | ov dout err  (ready before edge, outputs after)
        v(H, 8'hA5, H, 8'h3C, H,  H, H,  L, 16'h0000, L);
        v(L, 8'h00, L, 8'h00, H,  H, H,  H, 16'hA53C, L);
        v(L, 8'h00, L, 8'h00, H,  H, H,  L, 16'hA53C, L);
        v(H, 8'h11, L, 8'h00, H,  H, H,  L, 16'hA53C, L);
        for (int i = 0; i < 4; i++)
            v(L, 8'h00, L, 8'h00, H,  L, H,  L, 16'hA53C, L);
        v(L, 8'h00, H, 8'h22, H,  L, H,  L, 16'hA53C, L);
        v(L, 8'h00, L, 8'h00, H,  H, H,  H, 16'h1122, L);
        v(L, 8'h00, L, 8'h00, H,  H, H,  L, 16'h1122, L);
        v(H, 8'h01, H, 8'h02, L,  H, H,  L, 16'h1122, L);
        v(H, 8'h03, H, 8'h04, L,  H, H,  H, 16'h0102, L);
        v(H, 8'h05, H, 8'h06, L,  L, L,  H, 16'h0102, L);
        v(H, 8'h05, H, 8'h06, L,  L, L,  H, 16'h0102, L);
        v(H, 8'h05, H, 8'h06, H,  H, H,  H, 16'h0304, L);
        v(L, 8'h00, L, 8'h00, H,  H, H,  H, 16'h0506, L);
        v(L, 8'h00, L, 8'h00, H,  H, H,  L, 16'h0506, L);
        v(L, 8'h00, H, 8'hB1, H,  H, H,  L, 16'h0506, L);
        v(H, 8'hA1, L, 8'h00, H,  H, L,  L, 16'h0506, L);
        v(L, 8'h00, L, 8'h00, H,  H, H,  H, 16'hA1B1, L);
        v(L, 8'h00, L, 8'h00, H,  H, H,  L, 16'hA1B1, L);

        foreach (vq[i]) begin
            a_valid = vq[i].av; a_data = vq[i].ad;
            b_valid = vq[i].bv; b_data = vq[i].bd;
            out_ready = vq[i].ordy;
            #1;
            check($sformatf("vec%0d_a_ready", i), 32'(a_ready), 32'(vq[i].ar));
            check($sformatf("vec%0d_b_ready", i), 32'(b_ready), 32'(vq[i].br));
            step();
            check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vq[i].ov));
            check($sformatf("vec%0d_data_out", i), 32'(data_out), 32'(vq[i].dout));
            check($sformatf("vec%0d_orphan_err", i), 32'(orphan_err), 32'(vq[i].err));
        end
        a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b1;

        for (int k = 0; k <= 100; k++) begin
            if (k < 100) begin
                a_valid = 1'b1; a_data = 8'(k);
                b_valid = 1'b1; b_data = ~8'(k);
            end else begin
                a_valid = 1'b0; b_valid = 1'b0;
            end
            #1;
            check("stream_ready", 32'({a_ready, b_ready}), 32'd3);
            step();
            if (k >= 1) begin
                e = 8'(k - 1);
                check("stream_valid", 32'(out_valid), 32'd1);
                check("stream_word", 32'(data_out), 32'({e, ~e}));
            end
        end
        step();
        check("stream_drain", 32'(out_valid), 32'd0);

        a_valid = 1'b1; a_data = 8'hC1; b_valid = 1'b1; b_data = 8'hD1; out_ready = 1'b1;
        step();
        a_valid = 1'b1; a_data = 8'hE1; b_valid = 1'b0; out_ready = 1'b0;
        #1;
        check("pre_rst_a_ready", 32'(a_ready), 32'd1);
        step();
        a_valid = 1'b0;
        check("pre_rst_out_valid", 32'(out_valid), 32'd1);
        check("pre_rst_data_out", 32'(data_out), 32'hC1D1);
        check("pre_rst_a_blocked", 32'(a_ready), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data_out", 32'(data_out), 32'd0);
        check("mid_rst_ready", 32'({a_ready, b_ready}), 32'd3);
        check("mid_rst_orphan_cnt", 32'(orphan_cnt), 32'd0);
        check("mid_rst_orphan_err", 32'(orphan_err), 32'd0);
        b_valid = 1'b1; b_data = 8'hF1; out_ready = 1'b1;
        step();
        b_valid = 1'b0;
        step();
        check("mid_rst_hold_a_cleared", 32'(out_valid), 32'd0);

        t_a_valid = 1'b1; t_a_data = 8'h77;
        step();
        t_a_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            check("to_a_ready_held", 32'(t_a_ready), 32'd0);
            step();
            check($sformatf("to_err_c%0d", c), 32'(t_orphan_err), 32'(c == 4));
        end
        check("to_cnt_1", 32'(t_orphan_cnt), 32'd1);
        check("to_a_ready_freed", 32'(t_a_ready), 32'd1);
        check("to_no_output", 32'(t_out_valid), 32'd0);
        step();
        check("to_err_one_cycle", 32'(t_orphan_err), 32'd0);
        t_a_valid = 1'b1; t_a_data = 8'h99; t_b_valid = 1'b1; t_b_data = 8'h88;
        step();
        t_a_valid = 1'b0; t_b_valid = 1'b0;
        step();
        check("to_after_valid", 32'(t_out_valid), 32'd1);
        check("to_after_word", 32'(t_data_out), 32'h9988);

        t_a_valid = 1'b1; t_a_data = 8'h55;
        step();
        t_a_valid = 1'b0;
        for (int c = 0; c < 3; c++) step();
        t_b_valid = 1'b1; t_b_data = 8'h66;
        #1;
        check("to_edge_b_ready", 32'(t_b_ready), 32'd1);
        step();
        t_b_valid = 1'b0;
        check("to_edge_no_err", 32'(t_orphan_err), 32'd0);
        step();
        check("to_edge_word", 32'(t_data_out), 32'h5566);
        check("to_edge_cnt", 32'(t_orphan_cnt), 32'd1);

        sat_exp[0] = 2'd2; sat_exp[1] = 2'd3; sat_exp[2] = 2'd3;
        for (int n = 0; n < 3; n++) begin
            t_b_valid = 1'b1; t_b_data = 8'(n);
            step();
            t_b_valid = 1'b0;
            for (int c = 0; c < 4; c++) step();
            check($sformatf("sat_cnt%0d", n), 32'(t_orphan_cnt), 32'(sat_exp[n]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
